// File: rtl/fir_sample_sequencer.sv
// fir_sample_sequencer: writes each accepted sample into a circular buffer in
// the sample memory, then streams the newest NTAPS samples (newest first) to the MAC.
module fir_sample_sequencer #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16,
    parameter int NTAPS  = 16,
    parameter int IDX_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              tap_valid,
    input  logic              tap_ready,
    output logic [DATA_W-1:0] tap_data,
    output logic [IDX_W-1:0]  tap_index,
    output logic              tap_last,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_write_enable_n,
    input  logic [DATA_W-1:0] mem_data_out
);
    // k and fill share one width so the warm-up compare needs no extension
    localparam int CW = $clog2(NTAPS + 1);

    typedef enum logic [2:0] {IDLE, WRITE, RD_ADDR, RD_DATA, OUT} state_t;

    state_t            state, next;
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0]     k, fill;
    logic [DATA_W-1:0] sample;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            IDLE:    if (s_valid) next = WRITE;
            WRITE:   next = RD_ADDR;
            RD_ADDR: next = RD_DATA;
            RD_DATA: next = OUT;
            OUT:     if (tap_ready) next = tap_last ? IDLE : RD_ADDR;
            default: next = IDLE;
        endcase
        if (flush) next = IDLE;
    end

    assign s_ready            = state == IDLE;
    assign tap_valid          = state == OUT;
    // read address is held across issue and capture cycles for the bank mux
    assign mem_address        = (state == RD_ADDR || state == RD_DATA) ? rd_ptr : wr_ptr;
    // flush suppresses the write so an aborted WRITE never commits
    assign mem_write_enable_n = !(state == WRITE && !flush);
    assign mem_data_in        = sample;
    assign tap_index          = IDX_W'(k);
    assign tap_last           = k == CW'(NTAPS - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            k        <= '0;
            fill     <= '0;
            sample   <= '0;
            tap_data <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            k      <= '0;
            fill   <= '0;
        end else begin
            case (state)
                IDLE: if (s_valid) sample <= s_data;
                WRITE: begin
                    rd_ptr <= wr_ptr;
                    wr_ptr <= wr_ptr + ADDR_W'(1);
                    fill   <= (fill == CW'(NTAPS)) ? fill : fill + CW'(1);
                    k      <= '0;
                end
                // locations never written since reset/flush read as zero
                RD_DATA: tap_data <= (k < fill) ? mem_data_out : '0;
                OUT: if (tap_ready) begin
                    rd_ptr <= rd_ptr - ADDR_W'(1);
                    k      <= k + CW'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fir_sample_sequencer.sv
// tb_fir_sample_sequencer: randomized bench with a sample-history reference
// model and a behavioural one-cycle-latency memory.
module tb_fir_sample_sequencer;
    localparam int AW = 12;
    localparam int DW = 16;
    localparam int NT = 4;

    logic          clk = 0, rst_n = 0, flush = 0, s_valid = 0, tap_ready = 0;
    logic          s_ready, tap_valid, tap_last, we_n;
    logic [DW-1:0] s_data = '0, tap_data, din, dout;
    logic [7:0]    tap_index;
    logic [AW-1:0] addr;
    logic [DW-1:0] mem [0:(1<<AW)-1];

    int checks = 0, errors = 0;

    logic [DW-1:0] hist[$];
    int            wcount = 0;
    logic [AW-1:0] wlog_a[$];
    logic [DW-1:0] wlog_d[$];

    logic [DW-1:0] got_d[NT];
    int            got_i[NT];
    logic          got_l[NT];
    int            got_n;

    always #5 clk = ~clk;

    fir_sample_sequencer #(.ADDR_W(AW), .DATA_W(DW), .NTAPS(NT)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .tap_valid(tap_valid), .tap_ready(tap_ready), .tap_data(tap_data),
        .tap_index(tap_index), .tap_last(tap_last),
        .mem_address(addr), .mem_data_in(din),
        .mem_write_enable_n(we_n), .mem_data_out(dout)
    );

    // junk contents so zero-fill masking is actually exercised
    initial for (int i = 0; i < (1 << AW); i++) mem[i] <= DW'($urandom);

    always @(posedge clk) begin
        if (!we_n) begin
            mem[addr] <= din;
            wlog_a.push_back(addr);
            wlog_d.push_back(din);
        end
        dout <= mem[addr];
    end

    function automatic logic [DW-1:0] exp_tap(int k);
        return (k < hist.size()) ? hist[k] : '0;
    endfunction

    function automatic void model_write(logic [DW-1:0] d);
        hist.push_front(d);
        if (hist.size() > NT) void'(hist.pop_back());
        wcount++;
    endfunction

    function automatic void model_clear();
        hist.delete();
        wcount = 0;
    endfunction

    task automatic do_reset();
        rst_n = 0; flush = 0; s_valid = 0; tap_ready = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        model_clear();
        wlog_a.delete();
        wlog_d.delete();
        @(negedge clk);
    endtask

    task automatic send(input logic [DW-1:0] d);
        int n = 0;
        s_valid = 1;
        s_data  = d;
        while (!s_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        s_valid = 0;
        model_write(d);
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL send_timeout: s_ready=%b after %0d cycles, want 1", s_ready, n);
        end
    endtask

    task automatic collect(input int first, input int n, input int stall);
        int cyc = 0;
        got_n = 0;
        while (got_n < n && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            tap_ready = ($urandom_range(99) >= stall);
            if (tap_valid && tap_ready) begin
                got_d[first+got_n] = tap_data;
                got_i[first+got_n] = int'(tap_index);
                got_l[first+got_n] = tap_last;
                got_n++;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 0;
        #1;
        checks++;
        if (s_ready !== 1 || tap_valid !== 0 || tap_data !== 0 || tap_index !== 0 || tap_last !== 0) begin
            errors++;
            $display("FAIL reset_stream: ready=%b valid=%b data=%h idx=%0d last=%b, want 1 0 0000 0 0",
                     s_ready, tap_valid, tap_data, tap_index, tap_last);
        end
        checks++;
        if (we_n !== 1 || addr !== 0 || din !== 0) begin
            errors++;
            $display("FAIL reset_mem: we_n=%b addr=%h din=%h, want 1 000 0000", we_n, addr, din);
        end
        do_reset();
    endtask

    task automatic test_single();
        int n = 0;
        do_reset();
        send(16'h1234);
        while (!tap_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n !== 3) begin
            errors++;
            $display("FAIL first_tap_latency: %0d cycles after WRITE, want 3", n);
        end
        collect(0, NT, 0);
        checks++;
        if (got_n !== NT) begin
            errors++;
            $display("FAIL single_tap_count: got %0d, want %0d", got_n, NT);
        end
        for (int k = 0; k < NT; k++) begin
            checks++;
            if (got_d[k] !== ((k == 0) ? 16'h1234 : 16'h0) || got_i[k] !== k || got_l[k] !== (k == NT - 1)) begin
                errors++;
                $display("FAIL single_tap%0d: data=%h idx=%0d last=%b, want %h %0d %b",
                         k, got_d[k], got_i[k], got_l[k], (k == 0) ? 16'h1234 : 16'h0, k, k == NT - 1);
            end
        end
        @(negedge clk);
        checks++;
        if (s_ready !== 1) begin
            errors++;
            $display("FAIL single_ready_return: s_ready=%b, want 1", s_ready);
        end
        checks++;
        if (wlog_a.size() !== 1 || wlog_a[0] !== 0 || wlog_d[0] !== 16'h1234 || mem[0] !== 16'h1234) begin
            errors++;
            $display("FAIL single_write: writes=%0d addr=%h data=%h mem0=%h, want 1 000 1234 1234",
                     wlog_a.size(), wlog_a[0], wlog_d[0], mem[0]);
        end
    endtask

    task automatic test_sequence();
        do_reset();
        for (int v = 1; v <= 5; v++) begin
            send(DW'(v));
            collect(0, NT, 25);
            for (int k = 0; k < NT; k++) begin
                checks++;
                if (got_d[k] !== exp_tap(k) || got_i[k] !== k || got_l[k] !== (k == NT - 1)) begin
                    errors++;
                    $display("FAIL seq%0d_tap%0d: data=%h idx=%0d last=%b, want %h %0d %b",
                             v, k, got_d[k], got_i[k], got_l[k], exp_tap(k), k, k == NT - 1);
                end
            end
        end
        checks++;
        if (got_d[0] !== 5 || got_d[1] !== 4 || got_d[2] !== 3 || got_d[3] !== 2) begin
            errors++;
            $display("FAIL seq_fifth: %h %h %h %h, want 0005 0004 0003 0002", got_d[0], got_d[1], got_d[2], got_d[3]);
        end
        send(DW'(6));
        collect(0, NT, 0);
        checks++;
        if (wlog_a[$] !== 5 || wlog_d[$] !== 6) begin
            errors++;
            $display("FAIL seq_sixth_write: addr=%h data=%h, want 005 0006", wlog_a[$], wlog_d[$]);
        end
    endtask

    task automatic test_random();
        for (int s = 0; s < 20; s++) begin
            logic [DW-1:0] d;
            logic [AW-1:0] ea;
            d  = DW'($urandom);
            ea = AW'(wcount);
            send(d);
            collect(0, NT, 40);
            checks++;
            if (wlog_a[$] !== ea || wlog_d[$] !== d) begin
                errors++;
                $display("FAIL rand%0d_write: addr=%h data=%h, want %h %h", s, wlog_a[$], wlog_d[$], ea, d);
            end
            for (int k = 0; k < NT; k++) begin
                checks++;
                if (got_d[k] !== exp_tap(k) || got_i[k] !== k || got_l[k] !== (k == NT - 1)) begin
                    errors++;
                    $display("FAIL rand%0d_tap%0d: data=%h idx=%0d last=%b, want %h %0d %b",
                             s, k, got_d[k], got_i[k], got_l[k], exp_tap(k), k, k == NT - 1);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] v0;
        logic [7:0]    i0;
        logic          l0;
        int            ws, n;
        send(DW'($urandom));
        tap_ready = 0;
        n = 0;
        while (!tap_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        v0 = tap_data; i0 = tap_index; l0 = tap_last; ws = wlog_a.size();
        checks++;
        if (!tap_valid || v0 !== exp_tap(0) || i0 !== 0) begin
            errors++;
            $display("FAIL bp_first: valid=%b data=%h idx=%0d, want 1 %h 0", tap_valid, v0, i0, exp_tap(0));
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if (tap_valid !== 1 || tap_data !== v0 || tap_index !== i0 || tap_last !== l0 || s_ready !== 0 || wlog_a.size() !== ws) begin
                errors++;
                $display("FAIL bp_hold%0d: valid=%b data=%h idx=%0d last=%b ready=%b writes=%0d, want 1 %h %0d %b 0 %0d",
                         c, tap_valid, tap_data, tap_index, tap_last, s_ready, wlog_a.size(), v0, i0, l0, ws);
            end
        end
        tap_ready = 1;
        @(negedge clk);
        tap_ready = 0;
        checks++;
        if (tap_valid !== 0) begin
            errors++;
            $display("FAIL bp_release: tap_valid=%b after handshake, want 0", tap_valid);
        end
        n = 0;
        while (!tap_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (tap_valid !== 1 || tap_index !== 1 || tap_data !== exp_tap(1)) begin
            errors++;
            $display("FAIL bp_advance: valid=%b idx=%0d data=%h, want 1 1 %h", tap_valid, tap_index, tap_data, exp_tap(1));
        end
        collect(1, NT - 1, 0);
        for (int k = 1; k < NT; k++) begin
            checks++;
            if (got_d[k] !== exp_tap(k) || got_i[k] !== k || got_l[k] !== (k == NT - 1)) begin
                errors++;
                $display("FAIL bp_tap%0d: data=%h idx=%0d last=%b, want %h %0d %b",
                         k, got_d[k], got_i[k], got_l[k], exp_tap(k), k, k == NT - 1);
            end
        end
    endtask

    task automatic test_flush();
        int            n, ws;
        logic [DW-1:0] d;
        send(DW'($urandom));
        collect(0, 2, 0);
        @(negedge clk);
        tap_ready = 0;
        n = 0;
        while (!tap_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (tap_index !== 2) begin
            errors++;
            $display("FAIL flush_third_tap: idx=%0d, want 2", tap_index);
        end
        flush = 1;
        @(negedge clk);
        flush = 0;
        model_clear();
        checks++;
        if (tap_valid !== 0 || s_ready !== 1) begin
            errors++;
            $display("FAIL flush_abort: valid=%b ready=%b, want 0 1", tap_valid, s_ready);
        end
        for (int r = 0; r < 2; r++) begin
            d = DW'($urandom) | 16'h0001;
            send(d);
            if (r == 1) begin
                ws = wlog_a.size();
                flush = 1;
                @(negedge clk);
                flush = 0;
                model_clear();
                checks++;
                if (wlog_a.size() !== ws || s_ready !== 1 || tap_valid !== 0) begin
                    errors++;
                    $display("FAIL flush_in_write: writes=%0d ready=%b valid=%b, want %0d 1 0",
                             wlog_a.size(), s_ready, tap_valid, ws);
                end
                d = DW'($urandom) | 16'h0001;
                send(d);
            end
            collect(0, NT, 20);
            checks++;
            if (wlog_a[$] !== 0 || wlog_d[$] !== d) begin
                errors++;
                $display("FAIL flush%0d_write: addr=%h data=%h, want 000 %h", r, wlog_a[$], wlog_d[$], d);
            end
            for (int k = 0; k < NT; k++) begin
                checks++;
                if (got_d[k] !== exp_tap(k) || got_i[k] !== k) begin
                    errors++;
                    $display("FAIL flush%0d_tap%0d: data=%h idx=%0d, want %h %0d", r, k, got_d[k], got_i[k], exp_tap(k), k);
                end
            end
            if (r == 0) begin
                @(negedge clk);
                flush = 1;
                @(negedge clk);
                flush = 0;
                model_clear();
            end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 4098; i++) begin
            send(DW'(i + 1));
            collect(0, NT, 0);
        end
        checks++;
        if (wlog_a[$] !== 1 || wlog_d[$] !== 4098) begin
            errors++;
            $display("FAIL wrap_write: addr=%h data=%0d, want 001 4098", wlog_a[$], wlog_d[$]);
        end
        for (int k = 0; k < NT; k++) begin
            checks++;
            if (got_d[k] !== DW'(4098 - k) || got_d[k] !== exp_tap(k) || got_i[k] !== k) begin
                errors++;
                $display("FAIL wrap_tap%0d: data=%0d idx=%0d, want %0d %0d", k, got_d[k], got_i[k], 4098 - k, k);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [DW-1:0] d;
        send(DW'($urandom));
        repeat (2) @(negedge clk);
        #2 rst_n = 0;
        #1;
        checks++;
        if (s_ready !== 1 || tap_valid !== 0 || tap_data !== 0 || tap_index !== 0 || tap_last !== 0 ||
            we_n !== 1 || addr !== 0 || din !== 0) begin
            errors++;
            $display("FAIL async_reset: ready=%b valid=%b data=%h idx=%0d last=%b we_n=%b addr=%h din=%h, want 1 0 0 0 0 1 0 0",
                     s_ready, tap_valid, tap_data, tap_index, tap_last, we_n, addr, din);
        end
        @(negedge clk);
        rst_n = 1;
        model_clear();
        d = DW'($urandom) | 16'h0001;
        send(d);
        collect(0, NT, 10);
        checks++;
        if (wlog_a[$] !== 0 || wlog_d[$] !== d) begin
            errors++;
            $display("FAIL async_next_write: addr=%h data=%h, want 000 %h", wlog_a[$], wlog_d[$], d);
        end
        for (int k = 0; k < NT; k++) begin
            checks++;
            if (got_d[k] !== exp_tap(k) || got_i[k] !== k) begin
                errors++;
                $display("FAIL async_tap%0d: data=%h idx=%0d, want %h %0d", k, got_d[k], got_i[k], exp_tap(k), k);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_sequence();
        test_random();
        test_backpressure();
        test_flush();
        test_wrap();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
